keyboard_decoder: RTL
=====================

# keyboard_decoder

Consumes raw PS/2 Set 2 scan codes from the `keyboard` receiver and turns make/break sequences into 8-bit key characters for the CPU. It tracks the break (0xF0) and extended (0xE0) prefixes, the Shift and Ctrl modifiers, and Caps Lock state. Characters go into a first-word-fall-through FIFO that the CPU-side I/O register drains with a read strobe. The block sits between `keyboard` (scancode/ready) and the memory-mapped keyboard data/status registers.

## Interface
- FIFO_DEPTH, 16, key FIFO entries; power of two, minimum 2.
- CLOCK_50  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- scancode  in  8  code from `keyboard`; stable while ready is high.
- ready  in  1  from the PS2_CLK domain; high for at least one CLOCK_50 period per received code.
- key_read  in  1  one-cycle pop strobe from the CPU register.
- key_valid  out  1  FIFO not empty.
- key_data  out  8  FIFO head character; 0x00 when empty.
- overflow  out  1  sticky; a character was dropped because the FIFO was full.
- caps_lock  out  1  current Caps Lock state (LED drive).

## Operation
- Input capture:
  - ready passes through a 2-flop synchroniser, then a rising-edge detector.
  - Each detected edge samples scancode once as one code event.
  - Level-high ready never produces a second event.
- Prefix FSM states: IDLE, BRK, EXT, EXT_BRK.
  - IDLE:
    - 0xF0 -> BRK.
    - 0xE0 -> EXT.
    - 0x12/0x59 sets shift_l/shift_r.
    - 0x14 sets ctrl.
    - 0x58 toggles caps_lock.
    - Any other code is translated; a nonzero result is pushed.
  - BRK: 0x12/0x59 clears shift_l/shift_r; 0x14 clears ctrl; nothing pushed; -> IDLE.
  - EXT:
    - 0xF0 -> EXT_BRK.
    - 0x14 sets ctrl.
    - Arrows push 0x75 up=0x80, 0x72 down=0x81, 0x6B left=0x82, 0x74 right=0x83.
    - Other codes ignored.
    - -> IDLE.
  - EXT_BRK: 0x14 clears ctrl; -> IDLE.
- Translation uses US layout; shift = shift_l|shift_r.
  - Letters (Set 2, e.g. a=0x1C, q=0x15, z=0x1A): lowercase ASCII; uppercase when shift XOR caps_lock.
  - Ctrl+letter gives uppercase & 0x1F (Ctrl+C -> 0x03). Ctrl has priority over shift/caps.
  - Digits 1-9,0 (0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46,0x45): '1'..'0'; with shift `!@#$%^&*()`.
  - Punctuation, unshifted/shifted: 0x4E '-'/'_', 0x55 '='/'+', 0x41 ','/'<', 0x49 '.'/'>', 0x4A '/'/'?', 0x4C ';'/':', 0x52 '\''/'"'.
  - Controls: 0x29 space 0x20, 0x5A enter 0x0D, 0x66 backspace 0x08, 0x0D tab 0x09, 0x76 esc 0x1B.
  - Unmapped codes produce 0x00 and push nothing.
  - Caps Lock does not affect digits or punctuation.
- FIFO:
  - Push when the FIFO is not full.
  - When full with no pop in the same cycle, the character is dropped and overflow is set. overflow clears only on reset.
  - key_read while key_valid pops the head. key_read while empty is ignored.
  - Simultaneous push and pop: both happen and occupancy is unchanged; this holds even when full.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset, after the first CLOCK_50 edge with reset high:
  - State IDLE; shift_l, shift_r, ctrl, caps_lock = 0.
  - FIFO empty; key_valid = 0, key_data = 0x00, overflow = 0.
  - Synchroniser flops = 0.
- Reset mid-sequence (e.g. after 0xF0) abandons the prefix; the next code is treated in IDLE.
- Latency: edge N is the first rising edge to sample ready=1.
  - The code event is decoded at edge N+2.
  - key_valid/key_data update after edge N+2.
- Pop: after the edge sampling key_read, key_data shows the next entry, or 0x00 and key_valid=0 if the FIFO is now empty.
- Throughput: one code per 3 CLOCK_50 cycles minimum. PS/2 delivers about 1 per 1 ms.

## Test plan
- Press/release 'a' (0x1C, 0xF0, 0x1C), each ready pulse 2 cycles -> exactly one entry 0x61; key_valid 3 cycles after ready is first sampled.
- Hold Shift (0x12), 0x1C, 0x16, release Shift (0xF0 0x12), 0x1C -> FIFO holds 0x41, 0x21, 0x61.
- Caps toggle (0x58 0xF0 0x58): caps_lock=1; then 0x1C -> 0x41; Shift+0x1C -> 0x61; 0x16 -> 0x31.
- Extended: E0 75 -> 0x80; E0 F0 75 -> nothing; E0 14, 0x21 -> 0x03; E0 F0 14, 0x21 -> 0x63.
- Fill: push FIFO_DEPTH+1 'a' presses with no reads -> key_valid=1, overflow=1, exactly 16 pops of 0x61, then key_valid=0, key_data=0x00; key_read when empty changes nothing.
- Full FIFO: assert key_read in the same cycle a push decodes -> occupancy stays 16, overflow stays 0. Then reset after a lone 0xF0, send 0x1C -> 0x61 pushed.

Source files
------------

// File: rtl/keyboard_decoder_if.sv
// Scan-code input, CPU pop strobe and key FIFO outputs of keyboard_decoder.
// The slave modport is the decoder; master is whatever drives the codes and reads keys.
interface keyboard_decoder_if;
    logic [7:0] scancode;
    logic       ready;
    logic       key_read;
    logic       key_valid;
    logic [7:0] key_data;
    logic       overflow;
    logic       caps_lock;

    modport master (
        output scancode, ready, key_read,
        input  key_valid, key_data, overflow, caps_lock
    );

    modport slave (
        input  scancode, ready, key_read,
        output key_valid, key_data, overflow, caps_lock
    );
endinterface

// File: rtl/keyboard_decoder.sv
// Turns PS/2 Set 2 make/break sequences into US-layout characters and queues them
// in a first-word-fall-through FIFO that the CPU drains with key_read.
module keyboard_decoder #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input logic          CLOCK_50,
    input logic          reset,
    keyboard_decoder_if.slave kbd
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_e;

    // Lowercase letter, unshifted and shifted glyphs for one code; zero when unmapped.
    function automatic logic [7:0] translate(input logic [7:0] code, input logic shift,
                                             input logic caps, input logic ctrl);
        logic [7:0] letter;
        logic [7:0] plain;
        logic [7:0] shifted;
        letter  = 8'h00;
        plain   = 8'h00;
        shifted = 8'h00;
        case (code)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            8'h16: begin plain = "1"; shifted = "!"; end
            8'h1E: begin plain = "2"; shifted = "@"; end
            8'h26: begin plain = "3"; shifted = "#"; end
            8'h25: begin plain = "4"; shifted = "$"; end
            8'h2E: begin plain = "5"; shifted = "%"; end
            8'h36: begin plain = "6"; shifted = "^"; end
            8'h3D: begin plain = "7"; shifted = "&"; end
            8'h3E: begin plain = "8"; shifted = "*"; end
            8'h46: begin plain = "9"; shifted = "("; end
            8'h45: begin plain = "0"; shifted = ")"; end
            8'h4E: begin plain = "-"; shifted = "_"; end
            8'h55: begin plain = "="; shifted = "+"; end
            8'h41: begin plain = ","; shifted = "<"; end
            8'h49: begin plain = "."; shifted = ">"; end
            8'h4A: begin plain = "/"; shifted = "?"; end
            8'h4C: begin plain = ";"; shifted = ":"; end
            8'h52: begin plain = 8'h27; shifted = 8'h22; end
            8'h29: begin plain = 8'h20; shifted = 8'h20; end
            8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
            8'h66: begin plain = 8'h08; shifted = 8'h08; end
            8'h0D: begin plain = 8'h09; shifted = 8'h09; end
            8'h76: begin plain = 8'h1B; shifted = 8'h1B; end
            default: ;
        endcase
        if (letter != 8'h00) begin
            if (ctrl)              return (letter - 8'h20) & 8'h1F;
            else if (shift ^ caps) return letter - 8'h20;
            else                   return letter;
        end
        return shift ? shifted : plain;
    endfunction

    state_e             state_q, state_d;
    logic               sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [7:0]         code1_q, code1_d, code2_q, code2_d;
    logic               shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic               ctrl_q, ctrl_d, caps_q, caps_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               key_valid_q, key_valid_d;
    logic [7:0]         key_data_q, key_data_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               event_c, push_req, push_en, pop, full;
    logic [7:0]         xlat, push_char;

    always_comb begin
        state_d     = state_q;
        sync1_d     = kbd.ready;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        code1_d     = kbd.scancode;
        code2_d     = code1_q;
        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        ctrl_d      = ctrl_q;
        caps_d      = caps_q;
        push_req    = 1'b0;
        push_char   = 8'h00;
        // Scancode is delayed alongside ready so it lines up with the detected edge.
        event_c     = sync2_q & ~sync3_q;
        xlat        = translate(code2_q, shift_l_q | shift_r_q, caps_q, ctrl_q);

        if (event_c) begin
            case (state_q)
                S_IDLE: begin
                    case (code2_q)
                        8'hF0:   state_d   = S_BRK;
                        8'hE0:   state_d   = S_EXT;
                        8'h12:   shift_l_d = 1'b1;
                        8'h59:   shift_r_d = 1'b1;
                        8'h14:   ctrl_d    = 1'b1;
                        8'h58:   caps_d    = ~caps_q;
                        default: begin
                            push_char = xlat;
                            push_req  = (xlat != 8'h00);
                        end
                    endcase
                end
                S_BRK: begin
                    if (code2_q == 8'h12) shift_l_d = 1'b0;
                    if (code2_q == 8'h59) shift_r_d = 1'b0;
                    if (code2_q == 8'h14) ctrl_d    = 1'b0;
                    state_d = S_IDLE;
                end
                S_EXT: begin
                    state_d = S_IDLE;
                    case (code2_q)
                        8'hF0:   state_d = S_EXT_BRK;
                        8'h14:   ctrl_d  = 1'b1;
                        8'h75:   begin push_char = 8'h80; push_req = 1'b1; end
                        8'h72:   begin push_char = 8'h81; push_req = 1'b1; end
                        8'h6B:   begin push_char = 8'h82; push_req = 1'b1; end
                        8'h74:   begin push_char = 8'h83; push_req = 1'b1; end
                        default: ;
                    endcase
                end
                S_EXT_BRK: begin
                    if (code2_q == 8'h14) ctrl_d = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
        full       = (count_q == CNT_W'(FIFO_DEPTH));
        pop        = kbd.key_read && (count_q != '0);
        push_en    = push_req && (!full || pop);
        overflow_d = overflow_q | (push_req && full && !pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_en);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push_en) - CNT_W'(pop);

        // Head bypass covers a character written into the slot that becomes the head.
        key_valid_d = (count_d != '0);
        if (count_d == '0)                         key_data_d = 8'h00;
        else if (push_en && (wr_ptr_q == rd_ptr_d)) key_data_d = push_char;
        else                                        key_data_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            code1_q     <= 8'h00;
            code2_q     <= 8'h00;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            ctrl_q      <= 1'b0;
            caps_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            key_valid_q <= 1'b0;
            key_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            code1_q     <= code1_d;
            code2_q     <= code2_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            ctrl_q      <= ctrl_d;
            caps_q      <= caps_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            key_valid_q <= key_valid_d;
            key_data_q  <= key_data_d;
        end
    end

    // Storage is masked by count, so it needs no reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset && push_en) mem_q[wr_ptr_q] <= push_char;
    end

    assign kbd.key_valid = key_valid_q;
    assign kbd.key_data  = key_data_q;
    assign kbd.overflow  = overflow_q;
    assign kbd.caps_lock = caps_q;
endmodule
